// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_arbiter
//  Description : Round-robin arbiter that shares one uart_tx among NUM_REQ byte
//                producers, with start/busy handshake and busy-timeout recovery.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int DATA_W       = 8,
  parameter int BUSY_TIMEOUT = 4,
  parameter int ID_W         = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        ack,
  output logic [ID_W-1:0]           grant_id,
  output logic                      active,
  output logic                      timeout_err,
  output logic                      tx_start,
  output logic [DATA_W-1:0]         tx_data,
  input  logic                      tx_busy
);

  localparam int                CNT_W       = 4;
  localparam logic [CNT_W-1:0]  TIMEOUT_CNT = CNT_W'(BUSY_TIMEOUT);
  localparam logic [ID_W:0]     PTR_ONE     = (ID_W+1)'(1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_BUSY = 2'd1,
    WAIT_DONE = 2'd2
  } state_t;

  state_t                state;
  logic [CNT_W-1:0]      cnt;
  logic [CNT_W-1:0]      cnt_inc;
  logic [ID_W-1:0]       last;

  logic [ID_W:0]         start;
  logic [2*NUM_REQ-1:0]  req_dbl;
  logic [NUM_REQ-1:0]    req_rot;
  logic                  any_req;
  logic [ID_W-1:0]       winner;
  logic [NUM_REQ-1:0]    win_onehot;
  logic [DATA_W-1:0]     win_data;

  // Rotate the request vector so bit 0 is the requester just after 'last';
  // the lowest set bit of the rotated vector is then the round-robin winner.
  assign start   = {1'b0, last} + PTR_ONE;
  assign req_dbl = {req, req};
  assign req_rot = NUM_REQ'(req_dbl >> start);
  assign any_req = |req;
  assign cnt_inc = cnt + CNT_W'(1);

  always_comb begin
    winner = '0;
    for (int j = NUM_REQ - 1; j >= 0; j--) begin
      if (req_rot[j]) begin
        if (int'(start) + j >= NUM_REQ) begin
          winner = ID_W'(int'(start) + j - NUM_REQ);
        end else begin
          winner = ID_W'(int'(start) + j);
        end
      end
    end
  end

  always_comb begin
    win_onehot = '0;
    win_data   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (winner == ID_W'(i)) begin
        win_onehot[i] = 1'b1;
        win_data      = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      cnt         <= '0;
      last        <= ID_W'(NUM_REQ - 1);
      ack         <= '0;
      grant_id    <= '0;
      active      <= 1'b0;
      timeout_err <= 1'b0;
      tx_start    <= 1'b0;
      tx_data     <= '0;
    end else begin
      tx_start    <= 1'b0;
      ack         <= '0;
      timeout_err <= 1'b0;
      case (state)
        IDLE: begin
          // A busy transmitter here means it was not reset with us; wait it out.
          if (!tx_busy && any_req) begin
            tx_data  <= win_data;
            tx_start <= 1'b1;
            ack      <= win_onehot;
            grant_id <= winner;
            last     <= winner;
            active   <= 1'b1;
            cnt      <= '0;
            state    <= WAIT_BUSY;
          end
        end
        WAIT_BUSY: begin
          if (tx_busy) begin
            state <= WAIT_DONE;
          end else begin
            cnt <= cnt_inc;
            if (cnt_inc == TIMEOUT_CNT) begin
              timeout_err <= 1'b1;
              active      <= 1'b0;
              state       <= IDLE;
            end
          end
        end
        WAIT_DONE: begin
          if (!tx_busy) begin
            active <= 1'b0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_tx_arbiter
//  Description : Table-driven cycle vectors plus directed corner sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_arbiter;

  logic        clk;
  logic        reset;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  ack;
  logic [1:0]  grant_id;
  logic        active;
  logic        timeout_err;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        tx_busy;

  int errors = 0;
  int checks = 0;

  uart_tx_arbiter #(
    .NUM_REQ(4), .DATA_W(8), .BUSY_TIMEOUT(4), .ID_W(2)
  ) dut (
    .clk(clk), .reset(reset), .req(req), .req_data(req_data),
    .ack(ack), .grant_id(grant_id), .active(active),
    .timeout_err(timeout_err), .tx_start(tx_start), .tx_data(tx_data),
    .tx_busy(tx_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [3:0]  req;
    logic [31:0] data;
    logic        busy;
    logic [3:0]  e_ack;
    logic [1:0]  e_gid;
    logic        e_act;
    logic        e_to;
    logic        e_st;
    logic [7:0]  e_txd;
  } vec_t;

  vec_t vt[$];

  localparam logic [31:0] D  = 32'h44332211;
  localparam logic [31:0] DA = 32'h443322A5;

  task automatic add(input logic r, input logic [3:0] rq, input logic [31:0] d,
                     input logic b, input logic [3:0] ea, input logic [1:0] eg,
                     input logic eact, input logic eto, input logic est,
                     input logic [7:0] etx);
    vec_t v;
    v.rst = r; v.req = rq; v.data = d; v.busy = b;
    v.e_ack = ea; v.e_gid = eg; v.e_act = eact; v.e_to = eto;
    v.e_st = est; v.e_txd = etx;
    vt.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic [3:0] ea, input logic [1:0] eg,
                            input logic eact, input logic eto, input logic est,
                            input logic [7:0] etx);
    chk({tag, ".ack"},         32'(ack),         32'(ea));
    chk({tag, ".grant_id"},    32'(grant_id),    32'(eg));
    chk({tag, ".active"},      32'(active),      32'(eact));
    chk({tag, ".timeout_err"}, 32'(timeout_err), 32'(eto));
    chk({tag, ".tx_start"},    32'(tx_start),    32'(est));
    chk({tag, ".tx_data"},     32'(tx_data),     32'(etx));
  endtask

  // Apply inputs on the falling edge, then sample 1 time unit after the rising edge.
  task automatic step(input logic r, input logic [3:0] rq, input logic [31:0] d,
                      input logic b);
    @(negedge clk);
    reset = r; req = rq; req_data = d; tx_busy = b;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  initial begin
    int n;
    reset = 1'b0; req = '0; req_data = '0; tx_busy = 1'b0;

    //   rst req      data busy  ack     gid  act to st txd
    add(0, 4'b0000, D,  0,    4'b0000, 0,   0,  0, 0, 8'h00); // reset
    add(0, 4'b1111, D,  0,    4'b0000, 0,   0,  0, 0, 8'h00); // reset beats req
    add(1, 4'b0001, DA, 0,    4'b0001, 0,   1,  0, 1, 8'hA5); // single request
    add(1, 4'b0000, DA, 0,    4'b0000, 0,   1,  0, 0, 8'hA5);
    add(1, 4'b0000, DA, 1,    4'b0000, 0,   1,  0, 0, 8'hA5);
    add(1, 4'b0000, DA, 1,    4'b0000, 0,   1,  0, 0, 8'hA5);
    add(1, 4'b0000, DA, 0,    4'b0000, 0,   0,  0, 0, 8'hA5);
    add(1, 4'b0000, DA, 0,    4'b0000, 0,   0,  0, 0, 8'hA5);
    add(0, 4'b0000, D,  0,    4'b0000, 0,   0,  0, 0, 8'h00); // reset
    add(1, 4'b1111, D,  0,    4'b0001, 0,   1,  0, 1, 8'h11); // all at once
    add(1, 4'b1110, D,  0,    4'b0000, 0,   1,  0, 0, 8'h11);
    add(1, 4'b1110, D,  1,    4'b0000, 0,   1,  0, 0, 8'h11);
    add(1, 4'b1110, D,  0,    4'b0000, 0,   0,  0, 0, 8'h11);
    add(1, 4'b1110, D,  0,    4'b0010, 1,   1,  0, 1, 8'h22);
    add(1, 4'b1100, D,  1,    4'b0000, 1,   1,  0, 0, 8'h22);
    add(1, 4'b1100, D,  0,    4'b0000, 1,   0,  0, 0, 8'h22);
    add(1, 4'b1100, D,  0,    4'b0100, 2,   1,  0, 1, 8'h33);
    add(1, 4'b1000, D,  1,    4'b0000, 2,   1,  0, 0, 8'h33);
    add(1, 4'b1000, D,  0,    4'b0000, 2,   0,  0, 0, 8'h33);
    add(1, 4'b1000, D,  0,    4'b1000, 3,   1,  0, 1, 8'h44);
    add(1, 4'b0000, D,  1,    4'b0000, 3,   1,  0, 0, 8'h44);
    add(1, 4'b0000, D,  0,    4'b0000, 3,   0,  0, 0, 8'h44);
    add(1, 4'b0100, D,  0,    4'b0100, 2,   1,  0, 1, 8'h33); // fairness
    add(1, 4'b0100, D,  1,    4'b0000, 2,   1,  0, 0, 8'h33);
    add(1, 4'b0101, D,  1,    4'b0000, 2,   1,  0, 0, 8'h33);
    add(1, 4'b0101, D,  0,    4'b0000, 2,   0,  0, 0, 8'h33);
    add(1, 4'b0101, D,  0,    4'b0001, 0,   1,  0, 1, 8'h11);
    add(1, 4'b0100, D,  1,    4'b0000, 0,   1,  0, 0, 8'h11);
    add(1, 4'b0100, D,  0,    4'b0000, 0,   0,  0, 0, 8'h11);
    add(1, 4'b0100, D,  0,    4'b0100, 2,   1,  0, 1, 8'h33);
    add(1, 4'b0000, D,  1,    4'b0000, 2,   1,  0, 0, 8'h33);
    add(1, 4'b0000, D,  0,    4'b0000, 2,   0,  0, 0, 8'h33);

    foreach (vt[i]) begin
      step(vt[i].rst, vt[i].req, vt[i].data, vt[i].busy);
      check_outs($sformatf("v%0d", i), vt[i].e_ack, vt[i].e_gid, vt[i].e_act,
                 vt[i].e_to, vt[i].e_st, vt[i].e_txd);
    end

    // Timeout: tx_busy never rises; requester 2 keeps requesting.
    step(1, 4'b0100, D, 0);
    check_outs("to.grant", 4'b0100, 2, 1, 0, 1, 8'h33);
    n = 0;
    do begin
      step(1, 4'b0100, D, 0);
      n++;
    end while (!timeout_err && n < 20);
    chk("to.latency", 32'(n), 32'd4);
    check_outs("to.pulse", 4'b0000, 2, 0, 1, 0, 8'h33);
    step(1, 4'b0100, D, 0);
    check_outs("to.regrant", 4'b0100, 2, 1, 0, 1, 8'h33);
    step(1, 4'b0000, D, 1);
    step(1, 4'b0000, D, 0);
    check_outs("to.idle", 4'b0000, 2, 0, 0, 0, 8'h33);

    // Reset in WAIT_DONE while the transmitter stays busy.
    step(1, 4'b0010, D, 0);
    check_outs("rs.grant", 4'b0010, 1, 1, 0, 1, 8'h22);
    step(1, 4'b0000, D, 1);
    step(0, 4'b1001, D, 1);
    check_outs("rs.clear", 4'b0000, 0, 0, 0, 0, 8'h00);
    step(0, 4'b1001, D, 1);
    check_outs("rs.hold", 4'b0000, 0, 0, 0, 0, 8'h00);
    for (int k = 0; k < 3; k++) begin
      step(1, 4'b1001, D, 1);
      check_outs($sformatf("rs.busy%0d", k), 4'b0000, 0, 0, 0, 0, 8'h00);
    end
    step(1, 4'b1001, D, 0);
    check_outs("rs.first", 4'b0001, 0, 1, 0, 1, 8'h11);
    step(1, 4'b0000, D, 1);
    step(1, 4'b0000, D, 0);

    // Busy at idle: no grant until tx_busy drops.
    for (int k = 0; k < 3; k++) begin
      step(1, 4'b0010, D, 1);
      chk($sformatf("bi.noack%0d", k), 32'(ack), 32'd0);
      chk($sformatf("bi.nostart%0d", k), 32'(tx_start), 32'd0);
    end
    step(1, 4'b0010, D, 0);
    check_outs("bi.grant", 4'b0010, 1, 1, 0, 1, 8'h22);
    step(1, 4'b0000, D, 0);
    check_outs("bi.after", 4'b0000, 1, 1, 0, 0, 8'h22);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
